// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: ALU op codes, the EX->MEM payload and the write-enable resolve helper.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int RIDX_W = 5;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'b00000,
        ALU_SUB  = 5'b00001,
        ALU_AND  = 5'b00010,
        ALU_OR   = 5'b00011,
        ALU_XOR  = 5'b00100,
        ALU_NOR  = 5'b00101,
        ALU_SLT  = 5'b00110,
        ALU_SLTU = 5'b00111,
        ALU_SLL  = 5'b01000,
        ALU_SRL  = 5'b01001,
        ALU_SRA  = 5'b01010,
        ALU_LUI  = 5'b01011,
        ALU_MOVZ = 5'b01100,
        ALU_SEB  = 5'b01101
    } alu_op_e;

    typedef struct packed {
        logic [DATA_W-1:0] alu_out;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic [RIDX_W-1:0] rd;
        logic [DATA_W-1:0] store_data;
    } ex_mem_t;

    // movz only writes when the ALU saw B==0; writes to r0 are always suppressed.
    function automatic logic resolve_regwrite(input logic regwrite, input logic movz,
                                              input logic alu_regw, input logic [RIDX_W-1:0] rd);
        return regwrite & (~movz | alu_regw) & (rd != '0);
    endfunction

endpackage

// File: rtl/ex_mem_skid_buf.sv
// Two-entry valid/ready skid buffer over ex_mem_t: an output register plus one skid register,
// so a stall on the output side never drops or duplicates an entry.
module ex_mem_skid_buf
    import cpu_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    flush,
    input  logic    in_valid,
    output logic    in_ready,
    input  ex_mem_t in_data,
    output logic    out_valid,
    input  logic    out_ready,
    output ex_mem_t out_data
);

    logic    skid_valid;
    ex_mem_t skid_data;
    logic    accept;
    logic    drain;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
            out_data   <= '0;
        end else if (flush) begin
            out_valid         <= 1'b0;
            skid_valid        <= 1'b0;
            in_ready          <= 1'b1;
            out_data.regwrite <= 1'b0;
            out_data.memread  <= 1'b0;
            out_data.memwrite <= 1'b0;
        end else if (skid_valid) begin
            // in_ready is low while the skid is occupied, so no accept can coincide here.
            if (drain) begin
                out_data   <= skid_data;
                skid_valid <= 1'b0;
                in_ready   <= 1'b1;
            end
        end else if (accept) begin
            if (!out_valid || drain) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else begin
                skid_valid <= 1'b1;
                in_ready   <= 1'b0;
            end
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    // Skid payload is only meaningful while skid_valid is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept && out_valid && !drain && !skid_valid) begin
            skid_data <= in_data;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline boundary: resolves the final register write and buffers through a 2-entry skid.
// Optional forwarding tap from the output register is enabled by defining EX_MEM_FWD_EN.
module ex_mem_stage #(
    parameter int DW = cpu_pkg::DATA_W,
    parameter int RW = cpu_pkg::RIDX_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic [DW-1:0] ex_alu_out,
    input  logic          ex_alu_regw,
    input  logic          ex_movz,
    input  logic          ex_regwrite,
    input  logic          ex_memread,
    input  logic          ex_memwrite,
    input  logic [RW-1:0] ex_rd,
    input  logic [DW-1:0] ex_store_data,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [DW-1:0] mem_alu_out,
    output logic          mem_regwrite,
    output logic          mem_memread,
    output logic          mem_memwrite,
    output logic [RW-1:0] mem_rd,
    output logic [DW-1:0] mem_store_data
`ifdef EX_MEM_FWD_EN
    ,
    output logic          fwd_valid,
    output logic [RW-1:0] fwd_rd,
    output logic [DW-1:0] fwd_data
`endif
);

    import cpu_pkg::*;

    ex_mem_t in_p0;
    ex_mem_t out_p1;

    always_comb begin
        in_p0            = '0;
        in_p0.alu_out    = ex_alu_out;
        in_p0.regwrite   = resolve_regwrite(ex_regwrite, ex_movz, ex_alu_regw, ex_rd);
        in_p0.memread    = ex_memread;
        in_p0.memwrite   = ex_memwrite;
        in_p0.rd         = ex_rd;
        in_p0.store_data = ex_store_data;
    end

    // ---- p0 -> p1: skid buffer boundary ----
    ex_mem_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (ex_valid),
        .in_ready  (ex_ready),
        .in_data   (in_p0),
        .out_valid (mem_valid),
        .out_ready (mem_ready),
        .out_data  (out_p1)
    );

    assign mem_alu_out    = out_p1.alu_out;
    assign mem_regwrite   = out_p1.regwrite;
    assign mem_memread    = out_p1.memread;
    assign mem_memwrite   = out_p1.memwrite;
    assign mem_rd         = out_p1.rd;
    assign mem_store_data = out_p1.store_data;

`ifdef EX_MEM_FWD_EN
    // Loads cannot forward from here: their data only exists after the MEM access.
    assign fwd_valid = mem_valid & mem_regwrite & ~mem_memread;
    assign fwd_rd    = mem_rd;
    assign fwd_data  = mem_alu_out;
`endif

`ifndef SYNTHESIS
    a_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        (ex_valid && ex_ready) |-> !(ex_memread && ex_memwrite));
`endif

endmodule
